// File: rtl/sync_toggle_counter.sv
// sync_toggle_counter: synchronous up-counter built from a chain of T flip-flop stages.
// Define SYNC_TOGGLE_COUNTER_TC_EN to add the combinational terminal-count output tc.
module sync_toggle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             T,
    output logic [WIDTH-1:0] Q
`ifdef SYNC_TOGGLE_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry;
    // Each stage toggles when T and every lower stage are all 1.
    always_comb begin
        count_d = count_q;
        carry   = T;
        for (int i = 0; i < WIDTH; i++) begin
            count_d[i] = count_q[i] ^ carry;
            carry      = carry & count_q[i];
        end
    end
    // reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n)
        if (reset_n) count_q <= '0;
        else         count_q <= count_d;
    assign Q = count_q;
`ifdef SYNC_TOGGLE_COUNTER_TC_EN
    assign tc = T & (&count_q);
`endif
endmodule

// File: tb/tb_sync_toggle_counter.sv
// tb_sync_toggle_counter: random and directed scoreboard bench for a 4-bit and a 2-bit counter.
module tb_sync_toggle_counter;
    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic [1:0] q2;
        logic       tc2;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       T = 1'b1;
    logic [3:0] Q;
    logic [1:0] Q2;
    logic       tc, tc2;
    exp_t       sb[$];
    int         m = 0, m2 = 0;
    int         checks = 0, passes = 0;

    sync_toggle_counter #(.WIDTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .T(T), .Q(Q)
`ifdef SYNC_TOGGLE_COUNTER_TC_EN
        , .tc(tc)
`endif
    );

    sync_toggle_counter #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .T(T), .Q(Q2)
`ifdef SYNC_TOGGLE_COUNTER_TC_EN
        , .tc(tc2)
`endif
    );

`ifndef SYNC_TOGGLE_COUNTER_TC_EN
    assign tc  = 1'b0;
    assign tc2 = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic exp_t model_exp(input logic t);
        exp_t e;
        e.q   = 4'(m);
        e.q2  = 2'(m2);
        e.tc  = t && (m == 15);
        e.tc2 = t && (m2 == 3);
        return e;
    endfunction

    // Drive one cycle at the falling edge and record what the next rising edge must produce.
    task automatic cycle(input logic r, input logic t);
        @(negedge clk);
        reset_n = r;
        T = t;
        if (r) begin
            m = 0;
            m2 = 0;
        end else if (t) begin
            m = (m + 1) % 16;
            m2 = (m2 + 1) % 4;
        end
        sb.push_back(model_exp(t));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", int'(Q), int'(e.q));
                chk("q_w2", int'(Q2), int'(e.q2));
`ifdef SYNC_TOGGLE_COUNTER_TC_EN
                chk("tc", int'(tc), int'(e.tc));
                chk("tc_w2", int'(tc2), int'(e.tc2));
`endif
            end
        end
    end

    initial begin
        int n;
        sb.push_back(model_exp(1'b1));
        #6 reset_n = 1'b0;
        T = 1'b1;
        m = 1;
        m2 = 1;
        sb.push_back(model_exp(1'b1));
        @(negedge clk);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 80; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
        n = 0;
        while (m != 9 && n < 40) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        chk("reach_nine", m, 9);
        @(negedge clk);
        T = 1'b1;
        #1 chk("pre_reset_q", int'(Q), 9);
        #1 reset_n = 1'b1;
        #1 chk("async_reset_q", int'(Q), 0);
        chk("async_reset_q_w2", int'(Q2), 0);
        m = 0;
        m2 = 0;
        sb.push_back(model_exp(1'b1));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
        @(posedge clk);
        #4 chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
